fwd_scoreboard: RTL

- Parametrised bypass/hazard unit for the in-order pipeline; successor to the fixed EX/MEM/WB forwarding logic.
- Holds its own shift-register scoreboard of in-flight producers (dest reg, write-enable, ready stage), one entry per downstream stage.
- Resolves NSRC source operands of the EX-stage consumer to the youngest matching producer, returns the forwarded data, and raises a stall when that producer's result is not yet available (load-use and any multi-cycle producer).

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/fwd_select.sv | 54 +++++
 rtl/fwd_scoreboard.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared pipeline types and ready-stage constants for the forwarding unit.
package cpu_types_pkg;

   localparam int REGW_DEF  = 5;
   localparam int DATAW_DEF = 32;
   localparam int RDYW_DEF  = 2;

   typedef logic [REGW_DEF-1:0]  regbits_t;
   typedef logic [DATAW_DEF-1:0] word_t;
   typedef logic [RDYW_DEF-1:0]  rdy_t;

   // Entry index at which a producer's result first sits in a pipeline latch.
   localparam rdy_t RDY_ALU  = rdy_t'(1);
   localparam rdy_t RDY_LOAD = rdy_t'(2);

endpackage

// File: rtl/fwd_select.sv
// Per-operand bypass selection: finds the youngest in-flight producer of one
// source register and either forwards its value or flags a hazard.
module fwd_select
   import cpu_types_pkg::*;
#(
   parameter int NSTAGE = 3,
   parameter int REGW   = 5,
   parameter int DATAW  = 32,
   parameter int RDYW   = 2
) (
   input  logic [NSTAGE-1:0]            ent_valid_i,
   input  logic [NSTAGE-1:0]            ent_regwr_i,
   input  logic [NSTAGE-1:0][REGW-1:0]  ent_dst_i,
   input  logic [NSTAGE-1:0][RDYW-1:0]  ent_rdy_i,
   input  logic [NSTAGE-1:0][DATAW-1:0] stage_data_i,
   input  logic [REGW-1:0]              src_i,
   input  logic                         src_used_i,
   output logic [RDYW-1:0]              sel_o,
   output logic [DATAW-1:0]             data_o,
   output logic                         hazard_o
);

   logic [NSTAGE-1:0] match;
   logic              hit;

   // Candidate producers; r0 is hardwired zero so it never matches.
   always_comb begin
      match = '0;
      for (int k = 0; k < NSTAGE; k++) begin
         match[k] = src_used_i && (src_i != '0) && ent_valid_i[k] &&
                    ent_regwr_i[k] && (ent_dst_i[k] == src_i);
      end
   end

   // Youngest match wins; it forwards only once it has reached its ready entry.
   always_comb begin
      sel_o    = '0;
      data_o   = '0;
      hazard_o = 1'b0;
      hit      = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (!hit && match[k]) begin
            hit = 1'b1;
            if (RDYW'(k + 1) >= ent_rdy_i[k]) begin
               sel_o  = RDYW'(k + 1);
               data_o = stage_data_i[k];
            end else begin
               hazard_o = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/fwd_scoreboard.sv
// Bypass/hazard unit: shift-register scoreboard of in-flight producers, one
// fwd_select per source operand, load-use stall and saturating stall counter.
// Entry index k in the comments is 1-based (entry 1 = MEM); array index k-1.
module fwd_scoreboard
   import cpu_types_pkg::*;
#(
   parameter int NSRC   = 3,
   parameter int NSTAGE = 3,
   parameter int REGW   = 5,
   parameter int DATAW  = 32,
   parameter int RDYW   = 2,
   parameter int STATW  = 16
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic                    freeze_i,
   input  logic                    flush_ex_i,
   input  logic                    ex_valid_i,
   input  logic                    ex_regwr_i,
   input  logic [REGW-1:0]         ex_dst_i,
   input  logic [RDYW-1:0]         ex_rdy_i,
   input  logic [NSRC*REGW-1:0]    src_i,
   input  logic [NSRC-1:0]         src_used_i,
   input  logic [NSTAGE*DATAW-1:0] stage_data_i,
   output logic [NSRC*RDYW-1:0]    fwd_sel_o,
   output logic [NSRC*DATAW-1:0]   fwd_data_o,
   output logic                    stall_o,
   output logic [STATW-1:0]        stall_cnt_o
);

   logic [NSTAGE-1:0]            ent_valid;
   logic [NSTAGE-1:0]            ent_regwr;
   logic [NSTAGE-1:0][REGW-1:0]  ent_dst;
   logic [NSTAGE-1:0][RDYW-1:0]  ent_rdy;
   logic [NSTAGE-1:0][DATAW-1:0] stage_data;
   logic [NSRC-1:0]              hazard;
   logic                         load_new;

   assign stage_data = stage_data_i;

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      fwd_select #(
         .NSTAGE (NSTAGE),
         .REGW   (REGW),
         .DATAW  (DATAW),
         .RDYW   (RDYW)
      ) u_sel (
         .ent_valid_i  (ent_valid),
         .ent_regwr_i  (ent_regwr),
         .ent_dst_i    (ent_dst),
         .ent_rdy_i    (ent_rdy),
         .stage_data_i (stage_data),
         .src_i        (src_i[s*REGW +: REGW]),
         .src_used_i   (src_used_i[s]),
         .sel_o        (fwd_sel_o[s*RDYW +: RDYW]),
         .data_o       (fwd_data_o[s*DATAW +: DATAW]),
         .hazard_o     (hazard[s])
      );
   end

   // A hazard only matters for a live, unsquashed EX instruction.
   always_comb begin
      stall_o  = (|hazard) && ex_valid_i && !flush_ex_i;
      load_new = ex_valid_i && !flush_ex_i && !stall_o;
   end

   // Scoreboard advances with the pipeline; stalled/flushed/empty EX leaves a bubble.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ent_valid <= '0;
         ent_regwr <= '0;
         ent_dst   <= '0;
         ent_rdy   <= '0;
      end else if (!freeze_i) begin
         for (int k = 1; k < NSTAGE; k++) begin
            ent_valid[k] <= ent_valid[k-1];
            ent_regwr[k] <= ent_regwr[k-1];
            ent_dst[k]   <= ent_dst[k-1];
            ent_rdy[k]   <= ent_rdy[k-1];
         end
         ent_valid[0] <= load_new;
         ent_regwr[0] <= load_new && ex_regwr_i;
         ent_dst[0]   <= load_new ? ex_dst_i : '0;
         ent_rdy[0]   <= load_new ? ex_rdy_i : '0;
      end
   end

   // Saturating count of stall cycles that actually cost a pipeline slot.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_cnt_o <= '0;
      end else if (!freeze_i && stall_o && (stall_cnt_o != '1)) begin
         stall_cnt_o <= stall_cnt_o + 1'b1;
      end
   end

endmodule
